// File: rtl/vp_mac_pkg.sv
// Shared types and constants for the temporal MAC job scheduler and its benches.
package vp_mac_pkg;

    // Job sequencing states, in the order a job walks through them.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SEND_PREC  = 3'd1,
        ST_SEND_SCALE = 3'd2,
        ST_STREAM     = 3'd3,
        ST_FLUSH      = 3'd4,
        ST_WAIT_RES   = 3'd5,
        ST_OUT        = 3'd6
    } sched_state_t;

    // Highest legal precision code.
    localparam logic [3:0] PREC_MAX  = 4'd8;

    // Precision codes understood by the MAC (activation bits / weight bits).
    localparam logic [3:0] PREC_A8W8 = 4'd0;
    localparam logic [3:0] PREC_A8W4 = 4'd1;
    localparam logic [3:0] PREC_A8W2 = 4'd2;
    localparam logic [3:0] PREC_A4W8 = 4'd3;
    localparam logic [3:0] PREC_A4W4 = 4'd4;
    localparam logic [3:0] PREC_A4W2 = 4'd5;
    localparam logic [3:0] PREC_A2W8 = 4'd6;
    localparam logic [3:0] PREC_A2W4 = 4'd7;
    localparam logic [3:0] PREC_A2W2 = 4'd8;

    // True when a precision code is one the MAC supports.
    function automatic logic prec_legal(input logic [3:0] prec);
        return (prec <= PREC_MAX);
    endfunction

endpackage

// File: rtl/axis_hold_reg.sv
// One-entry valid/ready holding register: accepts a beat when empty and keeps
// it stable on the output until the downstream side takes it.
module axis_hold_reg #(
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          valid_r;
    logic [DW-1:0] data_r;

    // Fill when empty, drain on the output handshake; a full entry never takes new data.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_r <= 1'b0;
            data_r  <= {DW{1'b0}};
        end else if (in_valid && !valid_r) begin
            valid_r <= 1'b1;
            data_r  <= in_data;
        end else if (valid_r && out_ready) begin
            valid_r <= 1'b0;
        end
    end

    assign in_ready  = !valid_r;
    assign out_valid = valid_r;
    assign out_data  = data_r;

endmodule

// File: rtl/vp_mac_scheduler.sv
// Job sequencer for one temporal MAC: wraps an operand stream with the
// precision, scale and flush beats the MAC expects, then returns its result.
module vp_mac_scheduler
    import vp_mac_pkg::*;
#(
    parameter int AXIS_DW = 32,
    parameter int LEN_W   = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               CMD_VALID,
    output logic               CMD_READY,
    input  logic [3:0]         CMD_PREC,
    input  logic [31:0]        CMD_SCALE,
    input  logic [LEN_W-1:0]   CMD_LEN,
    input  logic [7:0]         CMD_TID,
    input  logic               S_AXIS_TVALID,
    output logic               S_AXIS_TREADY,
    input  logic [AXIS_DW-1:0] S_AXIS_TDATA,
    input  logic               S_AXIS_TLAST,
    output logic               M_AXIS_TVALID,
    input  logic               M_AXIS_TREADY,
    output logic [AXIS_DW-1:0] M_AXIS_TDATA,
    output logic               M_AXIS_TLAST,
    output logic               M_AXIS_TUSER,
    output logic [7:0]         M_AXIS_TID,
    input  logic               MAC_AXIS_TVALID,
    output logic               MAC_AXIS_TREADY,
    input  logic [AXIS_DW-1:0] MAC_AXIS_TDATA,
    input  logic               MAC_AXIS_TLAST,
    input  logic [7:0]         MAC_AXIS_TID,
    output logic               R_AXIS_TVALID,
    input  logic               R_AXIS_TREADY,
    output logic [AXIS_DW-1:0] R_AXIS_TDATA,
    output logic [7:0]         R_AXIS_TID,
    output logic               BUSY,
    output logic [15:0]        JOBS_DONE,
    output logic               ERR
);

    localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    sched_state_t       state_r;
    sched_state_t       state_nxt_s;
    logic [3:0]         prec_r;
    logic [31:0]        scale_r;
    logic [7:0]         tid_r;
    logic [LEN_W-1:0]   cnt_r;
    logic               err_r;
    logic [15:0]        jobs_done_r;

    logic               cmd_ok_s;
    logic               cnt_last_s;
    logic               s_fire_s;
    logic               mac_fire_s;
    logic               r_fire_s;
    logic               cmd_ready_s;
    logic               m_valid_s;
    logic [AXIS_DW-1:0] m_data_s;
    logic               m_last_s;
    logic               m_user_s;
    logic               s_ready_s;
    logic               hold_in_valid_s;
    logic               hold_in_ready_s;
    logic               hold_out_valid_s;
    logic [AXIS_DW-1:0] hold_out_data_s;
    logic               unused_s;

    // The MAC's TLAST and the upper operand bits carry nothing this block needs.
    assign unused_s = ^{MAC_AXIS_TLAST, S_AXIS_TDATA[AXIS_DW-1:16]};

    assign cmd_ok_s   = prec_legal(CMD_PREC) && (CMD_LEN != {LEN_W{1'b0}});
    assign cnt_last_s = (cnt_r == CNT_ONE);
    assign s_fire_s   = (state_r == ST_STREAM) && S_AXIS_TVALID && M_AXIS_TREADY;
    assign mac_fire_s = hold_in_valid_s && hold_in_ready_s;
    assign r_fire_s   = hold_out_valid_s && R_AXIS_TREADY;

    // Per-state MAC beat contents, stream pass-through and next-state selection.
    always_comb begin
        state_nxt_s     = state_r;
        cmd_ready_s     = 1'b0;
        m_valid_s       = 1'b0;
        m_data_s        = {AXIS_DW{1'b0}};
        m_last_s        = 1'b0;
        m_user_s        = 1'b0;
        s_ready_s       = 1'b0;
        hold_in_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cmd_ready_s = 1'b1;
                if (CMD_VALID && cmd_ok_s) begin
                    state_nxt_s = ST_SEND_PREC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND_PREC: begin
                m_valid_s = 1'b1;
                m_user_s  = 1'b1;
                m_data_s  = AXIS_DW'(prec_r);
                if (M_AXIS_TREADY) begin
                    state_nxt_s = ST_SEND_SCALE;
                end else begin
                    state_nxt_s = ST_SEND_PREC;
                end
            end
            ST_SEND_SCALE: begin
                m_valid_s = 1'b1;
                m_data_s  = AXIS_DW'(scale_r);
                if (M_AXIS_TREADY) begin
                    state_nxt_s = ST_STREAM;
                end else begin
                    state_nxt_s = ST_SEND_SCALE;
                end
            end
            ST_STREAM: begin
                m_valid_s = S_AXIS_TVALID;
                s_ready_s = M_AXIS_TREADY;
                m_data_s  = AXIS_DW'(S_AXIS_TDATA[15:0]);
                m_last_s  = cnt_last_s;
                if (s_fire_s && cnt_last_s) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            ST_FLUSH: begin
                m_valid_s = 1'b1;
                m_last_s  = 1'b1;
                if (M_AXIS_TREADY) begin
                    state_nxt_s = ST_WAIT_RES;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            ST_WAIT_RES: begin
                hold_in_valid_s = MAC_AXIS_TVALID;
                if (MAC_AXIS_TVALID && hold_in_ready_s) begin
                    state_nxt_s = ST_OUT;
                end else begin
                    state_nxt_s = ST_WAIT_RES;
                end
            end
            ST_OUT: begin
                if (r_fire_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons any job in flight.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Descriptor latch, beat counter, sticky error and completed-job counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            prec_r      <= 4'd0;
            scale_r     <= 32'd0;
            tid_r       <= 8'd0;
            cnt_r       <= {LEN_W{1'b0}};
            err_r       <= 1'b0;
            jobs_done_r <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (CMD_VALID) begin
                        prec_r  <= CMD_PREC;
                        scale_r <= CMD_SCALE;
                        tid_r   <= CMD_TID;
                        cnt_r   <= CMD_LEN;
                        if (!cmd_ok_s) begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (s_fire_s) begin
                        cnt_r <= cnt_r - CNT_ONE;
                        // Producer framing is advisory: a wrong TLAST is flagged, the counter still rules.
                        if (S_AXIS_TLAST != cnt_last_s) begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_WAIT_RES: begin
                    if (mac_fire_s && (MAC_AXIS_TID != tid_r)) begin
                        err_r <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (r_fire_s) begin
                        jobs_done_r <= jobs_done_r + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    axis_hold_reg #(
        .DW (AXIS_DW)
    ) u_res_hold (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_valid  (hold_in_valid_s),
        .in_ready  (hold_in_ready_s),
        .in_data   (MAC_AXIS_TDATA),
        .out_valid (hold_out_valid_s),
        .out_ready (R_AXIS_TREADY),
        .out_data  (hold_out_data_s)
    );

    assign CMD_READY       = cmd_ready_s;
    assign S_AXIS_TREADY   = s_ready_s;
    assign M_AXIS_TVALID   = m_valid_s;
    assign M_AXIS_TDATA    = m_data_s;
    assign M_AXIS_TLAST    = m_last_s;
    assign M_AXIS_TUSER    = m_user_s;
    assign M_AXIS_TID      = tid_r;
    assign MAC_AXIS_TREADY = (state_r == ST_WAIT_RES) && hold_in_ready_s;
    assign R_AXIS_TVALID   = hold_out_valid_s;
    assign R_AXIS_TDATA    = hold_out_data_s;
    assign R_AXIS_TID      = tid_r;
    assign BUSY            = (state_r != ST_IDLE);
    assign JOBS_DONE       = jobs_done_r;
    assign ERR             = err_r;

endmodule
